// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
// Holds opcode/funct values, FSM state encodings, ALUOp codes and
// the encodings of every datapath mux select driven by the controller.
package multicycle_control_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  // Controller states
  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EX_R    = 4'd2,
    S_EX_SH   = 4'd3,
    S_EX_I    = 4'd4,
    S_EX_ADDR = 4'd5,
    S_MEM_RD  = 4'd6,
    S_MEM_WR  = 4'd7,
    S_WB_R    = 4'd8,
    S_WB_I    = 4'd9,
    S_WB_MEM  = 4'd10,
    S_BR      = 4'd11,
    S_JMP     = 4'd12,
    S_JR      = 4'd13,
    S_EXC     = 4'd14
  } stateT;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_NOR   = 4'd5;
  localparam logic [3:0] ALU_SLT   = 4'd6;
  localparam logic [3:0] ALU_SLTU  = 4'd7;
  localparam logic [3:0] ALU_SLL   = 4'd8;
  localparam logic [3:0] ALU_SRL   = 4'd9;
  localparam logic [3:0] ALU_SRA   = 4'd10;
  localparam logic [3:0] ALU_PASSA = 4'd12;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  // Register file write address select
  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  // Register file write data select
  localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
  localparam logic [1:0] MEMTOREG_MDR    = 2'b01;
  localparam logic [1:0] MEMTOREG_PC     = 2'b10;

  // ALU operand selects
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_A     = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // Shift-by-immediate R-types take the shamt operand path.
  function automatic logic isShiftFunct(input logic [5:0] funct);
    return (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
  endfunction

endpackage

// File: rtl/multicycle_control_alu_op_decode.sv
// ALU operation decoder shared with the single-cycle design.
// Ports:
//   OpCode, Funct : instruction fields IR[31:26] / IR[5:0]
//   ALUOp         : ALU operation code (ALU_* encodings)
//   ExtOp         : 1 = sign-extend the immediate
//   LuOp          : 1 = immediate is shifted into the upper half (lui)
module alu_op_decode
  import multicycle_control_pkg::*;
(
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  output logic [3:0] ALUOp,
  output logic       ExtOp,
  output logic       LuOp
);

  always_comb begin
    ALUOp = ALU_ADD;
    ExtOp = 1'b1;
    LuOp  = 1'b0;
    case (OpCode)
      OP_RTYPE: begin
        case (Funct)
          FN_ADD, FN_ADDU: ALUOp = ALU_ADD;
          FN_SUB, FN_SUBU: ALUOp = ALU_SUB;
          FN_AND:          ALUOp = ALU_AND;
          FN_OR:           ALUOp = ALU_OR;
          FN_XOR:          ALUOp = ALU_XOR;
          FN_NOR:          ALUOp = ALU_NOR;
          FN_SLT:          ALUOp = ALU_SLT;
          FN_SLTU:         ALUOp = ALU_SLTU;
          FN_SLL:          ALUOp = ALU_SLL;
          FN_SRL:          ALUOp = ALU_SRL;
          FN_SRA:          ALUOp = ALU_SRA;
          FN_JR, FN_JALR:  ALUOp = ALU_PASSA;
          default:         ALUOp = ALU_ADD;
        endcase
      end
      OP_ADDI, OP_ADDIU: ALUOp = ALU_ADD;
      OP_SLTI:           ALUOp = ALU_SLT;
      OP_SLTIU:          ALUOp = ALU_SLTU;
      OP_ANDI: begin
        ALUOp = ALU_AND;
        ExtOp = 1'b0;       // logical immediates are zero-extended
      end
      OP_LUI: begin
        // imm << 16 added to rs ($0) yields the upper immediate
        ALUOp = ALU_ADD;
        ExtOp = 1'b0;
        LuOp  = 1'b1;
      end
      OP_LW, OP_SW:      ALUOp = ALU_ADD;
      OP_BEQ, OP_BNE:    ALUOp = ALU_SUB;
      default:           ALUOp = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit: a Moore FSM walking each instruction
// through fetch, decode, execute, memory and write-back, driving the
// shared-memory datapath enables and mux selects every cycle.
// Ports:
//   clk, reset        : clock (rising edge), asynchronous active-high reset
//   OpCode, Funct     : instruction register fields
//   Zero              : ALU zero flag (branch gating happens in the datapath)
//   mem_ready         : memory access completes this cycle
//   irq               : level interrupt request
//   PCWrite .. EPCWrite : datapath control (see package for encodings)
//   state             : current FSM state, for debug
//   retired           : count of completed instructions
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned MEM_HANDSHAKE = 1,
  parameter int unsigned SUPPORT_EXC   = 1,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           OpCode,
  input  logic [5:0]           Funct,
  input  logic                 Zero,
  input  logic                 mem_ready,
  input  logic                 irq,
  output logic                 PCWrite,
  output logic                 PCWriteCond,
  output logic                 BranchNe,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           MemtoReg,
  output logic [1:0]           RegDst,
  output logic                 RegWrite,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [3:0]           ALUOp,
  output logic                 ExtOp,
  output logic                 LuOp,
  output logic [1:0]           PCSource,
  output logic                 EPCWrite,
  output logic [3:0]           state,
  output logic [CNT_WIDTH-1:0] retired
);

  stateT                stateReg;
  stateT                stateNext;
  logic                 ifEntryReg;    // first cycle spent in IF
  logic [CNT_WIDTH-1:0] retiredReg;
  logic                 memDone;
  logic                 irqTake;
  logic                 retire;
  logic [3:0]           decAluOp;
  logic                 decExtOp;
  logic                 decLuOp;

  // The branch decision (Zero vs. BranchNe) is resolved in the datapath.
  logic unusedZero;
  assign unusedZero = Zero;

  alu_op_decode uAluOpDecode (
    .OpCode (OpCode),
    .Funct  (Funct),
    .ALUOp  (decAluOp),
    .ExtOp  (decExtOp),
    .LuOp   (decLuOp)
  );

  assign memDone = (MEM_HANDSHAKE == 0) || mem_ready;
  // Interrupts are only taken at the first IF cycle so an in-flight
  // fetch never loses its read strobe.
  assign irqTake = (SUPPORT_EXC != 0) && irq && ifEntryReg;
  // An exception return is not a completed instruction.
  assign retire  = (stateNext == S_IF) && (stateReg != S_IF) && (stateReg != S_EXC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg   <= S_IF;
      ifEntryReg <= 1'b1;
      retiredReg <= '0;
    end else begin
      stateReg   <= stateNext;
      ifEntryReg <= (stateNext == S_IF) && (stateReg != S_IF);
      if (retire) begin
        retiredReg <= retiredReg + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    stateNext   = stateReg;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNe    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = MEMTOREG_ALUOUT;
    RegDst      = REGDST_RT;
    RegWrite    = 1'b0;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_B;
    ALUOp       = ALU_ADD;
    ExtOp       = 1'b0;
    LuOp        = 1'b0;
    PCSource    = PCSRC_ALU;
    EPCWrite    = 1'b0;

    // Reset overrides the decode so nothing is written while it is held.
    if (!reset) begin
      case (stateReg)
        S_IF: begin
          ALUSrcA = SRCA_PC;
          ALUSrcB = SRCB_FOUR;
          ALUOp   = ALU_ADD;
          if (irqTake) begin
            stateNext = S_EXC;
          end else begin
            MemRead = 1'b1;
            if (memDone) begin
              IRWrite   = 1'b1;
              PCWrite   = 1'b1;
              stateNext = S_ID;
            end
          end
        end

        S_ID: begin
          // Speculatively compute the branch target into ALUOut.
          ALUSrcA = SRCA_PC;
          ALUSrcB = SRCB_IMMSH;
          ExtOp   = 1'b1;
          case (OpCode)
            OP_RTYPE: begin
              if (isShiftFunct(Funct)) begin
                stateNext = S_EX_SH;
              end else if ((Funct == FN_JR) || (Funct == FN_JALR)) begin
                stateNext = S_JR;
              end else begin
                stateNext = S_EX_R;
              end
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_SLTI, OP_SLTIU, OP_LUI:
              stateNext = S_EX_I;
            OP_LW, OP_SW:   stateNext = S_EX_ADDR;
            OP_BEQ, OP_BNE: stateNext = S_BR;
            OP_J, OP_JAL:   stateNext = S_JMP;
            default:        stateNext = (SUPPORT_EXC != 0) ? S_EXC : S_IF;
          endcase
        end

        S_EX_R: begin
          ALUSrcA   = SRCA_A;
          ALUSrcB   = SRCB_B;
          ALUOp     = decAluOp;
          stateNext = S_WB_R;
        end

        S_EX_SH: begin
          ALUSrcA   = SRCA_SHAMT;
          ALUSrcB   = SRCB_B;
          ALUOp     = decAluOp;
          stateNext = S_WB_R;
        end

        S_EX_I: begin
          ALUSrcA   = SRCA_A;
          ALUSrcB   = SRCB_IMM;
          ALUOp     = decAluOp;
          ExtOp     = decExtOp;
          LuOp      = decLuOp;
          stateNext = S_WB_I;
        end

        S_EX_ADDR: begin
          ALUSrcA   = SRCA_A;
          ALUSrcB   = SRCB_IMM;
          ALUOp     = ALU_ADD;
          ExtOp     = 1'b1;
          stateNext = (OpCode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        end

        S_MEM_RD: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
          if (memDone) begin
            stateNext = S_WB_MEM;
          end
        end

        S_MEM_WR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
          if (memDone) begin
            stateNext = S_IF;
          end
        end

        S_WB_R: begin
          RegDst    = REGDST_RD;
          MemtoReg  = MEMTOREG_ALUOUT;
          RegWrite  = 1'b1;
          stateNext = S_IF;
        end

        S_WB_I: begin
          RegDst    = REGDST_RT;
          MemtoReg  = MEMTOREG_ALUOUT;
          RegWrite  = 1'b1;
          ALUOp     = decAluOp;
          ExtOp     = decExtOp;
          LuOp      = decLuOp;
          stateNext = S_IF;
        end

        S_WB_MEM: begin
          MemtoReg  = MEMTOREG_MDR;
          RegDst    = REGDST_RT;
          RegWrite  = 1'b1;
          stateNext = S_IF;
        end

        S_BR: begin
          ALUSrcA     = SRCA_A;
          ALUSrcB     = SRCB_B;
          ALUOp       = ALU_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
          BranchNe    = OpCode[0];   // beq = 0x04, bne = 0x05
          stateNext   = S_IF;
        end

        S_JMP: begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_JUMP;
          if (OpCode == OP_JAL) begin
            RegWrite = 1'b1;
            RegDst   = REGDST_RA;
            MemtoReg = MEMTOREG_PC;
          end
          stateNext = S_IF;
        end

        S_JR: begin
          ALUSrcA  = SRCA_A;
          ALUOp    = ALU_PASSA;
          PCWrite  = 1'b1;
          PCSource = PCSRC_ALU;
          if (Funct == FN_JALR) begin
            RegWrite = 1'b1;
            RegDst   = REGDST_RD;
            MemtoReg = MEMTOREG_PC;
          end
          stateNext = S_IF;
        end

        S_EXC: begin
          EPCWrite  = 1'b1;
          PCWrite   = 1'b1;
          PCSource  = PCSRC_EXC;
          stateNext = S_IF;
        end

        default: stateNext = S_IF;
      endcase
    end
  end

  assign state   = stateReg;
  assign retired = retiredReg;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  OpCode = 6'h00;
  logic [5:0]  Funct = 6'h00;
  logic        Zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        irq = 1'b0;
  logic        PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite;
  logic [1:0]  MemtoReg, RegDst;
  logic        RegWrite;
  logic [1:0]  ALUSrcA, ALUSrcB;
  logic [3:0]  ALUOp;
  logic        ExtOp, LuOp;
  logic [1:0]  PCSource;
  logic        EPCWrite;
  logic [3:0]  state;
  logic [31:0] retired;

  multicycle_control #(.MEM_HANDSHAKE(1), .SUPPORT_EXC(1), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
    .mem_ready(mem_ready), .irq(irq), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .BranchNe(BranchNe), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtOp(ExtOp), .LuOp(LuOp),
    .PCSource(PCSource), .EPCWrite(EPCWrite), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcWrite, pcWriteCond, branchNe, iorD, memRead, memWrite, irWrite;
    logic [1:0] memtoReg, regDst;
    logic       regWrite;
    logic [1:0] aluSrcA, aluSrcB;
    logic [3:0] aluOp;
    logic       extOp, luOp;
    logic [1:0] pcSource;
    logic       epcWrite;
  } ctl_t;

  typedef struct {
    logic [5:0]  op, fn;
    logic        zero, rdy, irq;
    logic [3:0]  st;
    ctl_t        ctl;
    logic [31:0] ret;
  } vec_t;

  typedef struct {
    logic [3:0]  st;
    ctl_t        ctl;
    logic [31:0] ret;
    logic        pcLoad;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   passCount = 0;
  int   checkCount = 0;
  ctl_t actCtl;

  assign actCtl = {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
                   MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, ExtOp, LuOp,
                   PCSource, EPCWrite};

  task automatic check(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
  endtask

  // PC load as the datapath forms it from the control outputs.
  function automatic logic pcLoadOf(input ctl_t c, input logic z);
    return c.pcWrite | (c.pcWriteCond & (c.branchNe ? ~z : z));
  endfunction

  // Expected control words per state, written from the state descriptions.
  function automatic ctl_t cFetch(input logic rdy);
    ctl_t c = '0;
    c.memRead = 1'b1; c.aluSrcB = 2'b01; c.irWrite = rdy; c.pcWrite = rdy;
    return c;
  endfunction
  function automatic ctl_t cIrq();
    ctl_t c = '0;
    c.aluSrcB = 2'b01;
    return c;
  endfunction
  function automatic ctl_t cDecode();
    ctl_t c = '0;
    c.aluSrcB = 2'b11; c.extOp = 1'b1;
    return c;
  endfunction
  function automatic ctl_t cExR(input logic [3:0] op);
    ctl_t c = '0;
    c.aluSrcA = 2'b01; c.aluOp = op;
    return c;
  endfunction
  function automatic ctl_t cExSh(input logic [3:0] op);
    ctl_t c = '0;
    c.aluSrcA = 2'b10; c.aluOp = op;
    return c;
  endfunction
  function automatic ctl_t cExI(input logic [3:0] op, input logic ext, input logic lu);
    ctl_t c = '0;
    c.aluSrcA = 2'b01; c.aluSrcB = 2'b10; c.aluOp = op; c.extOp = ext; c.luOp = lu;
    return c;
  endfunction
  function automatic ctl_t cWbI(input logic [3:0] op, input logic ext, input logic lu);
    ctl_t c = '0;
    c.regWrite = 1'b1; c.aluOp = op; c.extOp = ext; c.luOp = lu;
    return c;
  endfunction
  function automatic ctl_t cWbR();
    ctl_t c = '0;
    c.regDst = 2'b01; c.regWrite = 1'b1;
    return c;
  endfunction
  function automatic ctl_t cExAddr();
    ctl_t c = '0;
    c.aluSrcA = 2'b01; c.aluSrcB = 2'b10; c.extOp = 1'b1;
    return c;
  endfunction
  function automatic ctl_t cMem(input logic wr);
    ctl_t c = '0;
    c.iorD = 1'b1; c.memRead = ~wr; c.memWrite = wr;
    return c;
  endfunction
  function automatic ctl_t cWbMem();
    ctl_t c = '0;
    c.memtoReg = 2'b01; c.regWrite = 1'b1;
    return c;
  endfunction
  function automatic ctl_t cBr(input logic ne);
    ctl_t c = '0;
    c.aluSrcA = 2'b01; c.aluOp = 4'd1; c.pcWriteCond = 1'b1; c.pcSource = 2'b01;
    c.branchNe = ne;
    return c;
  endfunction
  function automatic ctl_t cJmp(input logic link);
    ctl_t c = '0;
    c.pcWrite = 1'b1; c.pcSource = 2'b10;
    if (link) begin c.regWrite = 1'b1; c.regDst = 2'b10; c.memtoReg = 2'b10; end
    return c;
  endfunction
  function automatic ctl_t cJr(input logic link);
    ctl_t c = '0;
    c.pcWrite = 1'b1; c.aluSrcA = 2'b01; c.aluOp = ALU_PASSA;
    if (link) begin c.regWrite = 1'b1; c.regDst = 2'b01; c.memtoReg = 2'b10; end
    return c;
  endfunction
  function automatic ctl_t cExc();
    ctl_t c = '0;
    c.epcWrite = 1'b1; c.pcWrite = 1'b1; c.pcSource = 2'b11;
    return c;
  endfunction

  task automatic addRow(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                        input logic rdy, input logic irqIn, input stateT st,
                        input ctl_t c, input int ret);
    vec_t v;
    v.op = op; v.fn = fn; v.zero = zero; v.rdy = rdy; v.irq = irqIn;
    v.st = st; v.ctl = c; v.ret = ret;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    // add: 4 cycles
    addRow(6'h00, 6'h20, 0, 1, 0, S_IF,      cFetch(1),          0);
    addRow(6'h00, 6'h20, 0, 1, 0, S_ID,      cDecode(),          0);
    addRow(6'h00, 6'h20, 0, 1, 0, S_EX_R,    cExR(4'd0),         0);
    addRow(6'h00, 6'h20, 0, 1, 0, S_WB_R,    cWbR(),             0);
    // lw, memory ready arrives after 3 wait cycles
    addRow(6'h23, 6'h00, 0, 1, 0, S_IF,      cFetch(1),          1);
    addRow(6'h23, 6'h00, 0, 1, 0, S_ID,      cDecode(),          1);
    addRow(6'h23, 6'h00, 0, 1, 0, S_EX_ADDR, cExAddr(),          1);
    addRow(6'h23, 6'h00, 0, 0, 0, S_MEM_RD,  cMem(0),            1);
    addRow(6'h23, 6'h00, 0, 0, 0, S_MEM_RD,  cMem(0),            1);
    addRow(6'h23, 6'h00, 0, 0, 0, S_MEM_RD,  cMem(0),            1);
    addRow(6'h23, 6'h00, 0, 1, 0, S_MEM_RD,  cMem(0),            1);
    addRow(6'h23, 6'h00, 0, 1, 0, S_WB_MEM,  cWbMem(),           1);
    // beq not taken, bne taken (Zero = 0)
    addRow(6'h04, 6'h00, 0, 1, 0, S_IF,      cFetch(1),          2);
    addRow(6'h04, 6'h00, 0, 1, 0, S_ID,      cDecode(),          2);
    addRow(6'h04, 6'h00, 0, 1, 0, S_BR,      cBr(0),             2);
    addRow(6'h05, 6'h00, 0, 1, 0, S_IF,      cFetch(1),          3);
    addRow(6'h05, 6'h00, 0, 1, 0, S_ID,      cDecode(),          3);
    addRow(6'h05, 6'h00, 0, 1, 0, S_BR,      cBr(1),             3);
    // jal
    addRow(6'h03, 6'h00, 0, 1, 0, S_IF,      cFetch(1),          4);
    addRow(6'h03, 6'h00, 0, 1, 0, S_ID,      cDecode(),          4);
    addRow(6'h03, 6'h00, 0, 1, 0, S_JMP,     cJmp(1),            4);
    // illegal opcode traps, does not retire
    addRow(6'h3f, 6'h00, 0, 1, 0, S_IF,      cFetch(1),          5);
    addRow(6'h3f, 6'h00, 0, 1, 0, S_ID,      cDecode(),          5);
    addRow(6'h3f, 6'h00, 0, 1, 0, S_EXC,     cExc(),             5);
    // irq at IF entry wins over the fetch; irq ignored inside EXC
    addRow(6'h00, 6'h20, 0, 1, 1, S_IF,      cIrq(),             5);
    addRow(6'h00, 6'h20, 0, 1, 1, S_EXC,     cExc(),             5);
    // jalr
    addRow(6'h00, 6'h09, 0, 1, 0, S_IF,      cFetch(1),          5);
    addRow(6'h00, 6'h09, 0, 1, 0, S_ID,      cDecode(),          5);
    addRow(6'h00, 6'h09, 0, 1, 0, S_JR,      cJr(1),             5);
    // sll
    addRow(6'h00, 6'h00, 0, 1, 0, S_IF,      cFetch(1),          6);
    addRow(6'h00, 6'h00, 0, 1, 0, S_ID,      cDecode(),          6);
    addRow(6'h00, 6'h00, 0, 1, 0, S_EX_SH,   cExSh(ALU_SLL),     6);
    addRow(6'h00, 6'h00, 0, 1, 0, S_WB_R,    cWbR(),             6);
    // andi (zero-extended)
    addRow(6'h0c, 6'h00, 0, 1, 0, S_IF,      cFetch(1),          7);
    addRow(6'h0c, 6'h00, 0, 1, 0, S_ID,      cDecode(),          7);
    addRow(6'h0c, 6'h00, 0, 1, 0, S_EX_I,    cExI(ALU_AND, 0, 0), 7);
    addRow(6'h0c, 6'h00, 0, 1, 0, S_WB_I,    cWbI(ALU_AND, 0, 0), 7);
    // lui
    addRow(6'h0f, 6'h00, 0, 1, 0, S_IF,      cFetch(1),          8);
    addRow(6'h0f, 6'h00, 0, 1, 0, S_ID,      cDecode(),          8);
    addRow(6'h0f, 6'h00, 0, 1, 0, S_EX_I,    cExI(4'd0, 0, 1),   8);
    addRow(6'h0f, 6'h00, 0, 1, 0, S_WB_I,    cWbI(4'd0, 0, 1),   8);
    // sw with a one-cycle fetch stall
    addRow(6'h2b, 6'h00, 0, 0, 0, S_IF,      cFetch(0),          9);
    addRow(6'h2b, 6'h00, 0, 1, 0, S_IF,      cFetch(1),          9);
    addRow(6'h2b, 6'h00, 0, 1, 0, S_ID,      cDecode(),          9);
    addRow(6'h2b, 6'h00, 0, 1, 0, S_EX_ADDR, cExAddr(),          9);
    addRow(6'h2b, 6'h00, 0, 1, 0, S_MEM_WR,  cMem(1),            9);
    // j
    addRow(6'h02, 6'h00, 0, 1, 0, S_IF,      cFetch(1),          10);
    addRow(6'h02, 6'h00, 0, 1, 0, S_ID,      cDecode(),          10);
    addRow(6'h02, 6'h00, 0, 1, 0, S_JMP,     cJmp(0),            10);
    // sw stalled in MEM_WR, interrupted by reset below
    addRow(6'h2b, 6'h00, 0, 1, 0, S_IF,      cFetch(1),          11);
    addRow(6'h2b, 6'h00, 0, 1, 0, S_ID,      cDecode(),          11);
    addRow(6'h2b, 6'h00, 0, 1, 0, S_EX_ADDR, cExAddr(),          11);
    addRow(6'h2b, 6'h00, 0, 0, 0, S_MEM_WR,  cMem(1),            11);

    // Reset state: everything quiet even though the FSM sits in IF.
    @(negedge clk);
    check("rst_ctl", 0, 64'(actCtl), 64'(0));
    check("rst_state", 0, 64'(state), 64'(S_IF));
    check("rst_retired", 0, 64'(retired), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      OpCode = vecs[i].op; Funct = vecs[i].fn; Zero = vecs[i].zero;
      mem_ready = vecs[i].rdy; irq = vecs[i].irq;
      e.st = vecs[i].st; e.ctl = vecs[i].ctl; e.ret = vecs[i].ret;
      e.pcLoad = pcLoadOf(vecs[i].ctl, vecs[i].zero);
      sbq.push_back(e);
      @(negedge clk);
      if (sbq.size() == 0) begin
        check("sb_empty", i, 64'(1), 64'(0));
      end else begin
        e = sbq.pop_front();
        check("state", i, 64'(state), 64'(e.st));
        check("ctl", i, 64'(actCtl), 64'(e.ctl));
        check("retired", i, 64'(retired), 64'(e.ret));
        check("pc_load", i, 64'(pcLoadOf(actCtl, Zero)), 64'(e.pcLoad));
      end
      $display("row %0d: op=%h fn=%h rdy=%b irq=%b state=%0d ctl=%h retired=%0d",
               i, vecs[i].op, vecs[i].fn, vecs[i].rdy, vecs[i].irq, state, actCtl, retired);
      @(posedge clk); #1;
    end

    // Still stalled in MEM_WR; reset must kill the write strobe immediately.
    check("memwr_hold_state", 0, 64'(state), 64'(S_MEM_WR));
    check("memwr_hold_strobe", 0, 64'(MemWrite), 64'(1));
    #2 reset = 1'b1;
    #1;
    check("async_rst_memwrite", 0, 64'(MemWrite), 64'(0));
    check("async_rst_state", 0, 64'(state), 64'(S_IF));
    check("async_rst_retired", 0, 64'(retired), 64'(0));
    check("async_rst_ctl", 0, 64'(actCtl), 64'(0));
    $display("async reset in MEM_WR: state=%0d MemWrite=%b retired=%0d", state, MemWrite, retired);
    @(posedge clk); #1;
    check("rst_held_ctl", 0, 64'(actCtl), 64'(0));
    reset = 1'b0; OpCode = 6'h00; Funct = 6'h20; mem_ready = 1'b1;
    @(negedge clk);
    check("post_rst_ctl", 0, 64'(actCtl), 64'(cFetch(1)));
    @(posedge clk); #1;
    check("post_rst_state", 0, 64'(state), 64'(S_ID));
    $display("after reset release: state=%0d retired=%0d", state, retired);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle MIPS control decoder.
- A Moore FSM sequences each instruction through IF/ID/EX/MEM/WB and drives the datapath enables cycle by cycle.
- Adds a memory ready handshake, illegal-instruction and interrupt exceptions, and a retired-instruction counter.
- Sits between the instruction register and the shared-memory multi-cycle datapath.

Parameters:
- MEM_HANDSHAKE, 1: 1 = memory states wait for mem_ready; 0 = memory states always take exactly one cycle and mem_ready is ignored.
- SUPPORT_EXC, 1: 1 = EXC state, irq and illegal-opcode trap are enabled; 0 = EXC is unreachable, illegal opcodes execute as NOP, irq is ignored.
- CNT_WIDTH, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- OpCode  in  6  IR[31:26]; stable from the end of IF.
- Funct  in  6  IR[5:0].
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- irq  in  1  level interrupt request.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if branch taken.
- BranchNe  out  1  1 = taken on !Zero (bne); 0 = taken on Zero (beq).
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut.
- MemRead  out  1
- MemWrite  out  1
- IRWrite  out  1
- MemtoReg  out  2  00 = ALUOut, 01 = MDR, 10 = PC (link).
- RegDst  out  2  00 = rt, 01 = rd, 10 = $31.
- RegWrite  out  1
- ALUSrcA  out  2  00 = PC, 01 = A(rs), 10 = shamt.
- ALUSrcB  out  2  00 = B(rt), 01 = 4, 10 = ext imm, 11 = ext imm << 2.
- ALUOp  out  4  same encoding as the single-cycle decoder; 0000 = add.
- ExtOp  out  1  1 = sign extend.
- LuOp  out  1  1 = lui.
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target, 11 = exception vector.
- EPCWrite  out  1
- state  out  4  current state, for debug.
- retired  out  CNT_WIDTH  count of completed instructions.

Behaviour:
Clock, reset and output timing
- Single clock domain; reset is asynchronous and active-high.
- On reset: state = IF, retired = 0.
- While reset is high, all write/enable outputs (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, EPCWrite) are forced to 0 and all mux selects are 0.
- Outputs are a combinational decode of the state register plus OpCode/Funct.

States: IF, ID, EX_R, EX_SH, EX_I, EX_ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BR, JMP, JR, EXC.

IF
- Drive MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=add, PCSource=00.
- On mem_ready (or always when MEM_HANDSHAKE=0): IRWrite=1, PCWrite=1, go to ID. Otherwise hold in IF with IRWrite=0 and PCWrite=0.
- If SUPPORT_EXC and irq=1 on entry to IF: go to EXC instead. MemRead=0 that cycle; irq has priority over the fetch.

ID
- Drive ALUSrcA=00, ALUSrcB=11, ExtOp=1 to precompute the branch target into ALUOut.
- Next state by opcode:
  - R-type: sll/srl/sra -> EX_SH; jr -> JR; jalr -> JR; others -> EX_R.
  - addi, addiu, andi, slti, sltiu, lui -> EX_I.
  - lw, sw -> EX_ADDR.
  - beq, bne -> BR.
  - j, jal -> JMP.
  - Any other opcode -> EXC (SUPPORT_EXC=1) or IF (SUPPORT_EXC=0).

Execute, memory and write-back
- EX_R and EX_SH go to WB_R. WB_R: RegDst=01, MemtoReg=00, RegWrite=1.
- EX_I goes to WB_I. WB_I: RegDst=00, RegWrite=1. ExtOp, LuOp and ALUOp are decoded per opcode exactly as in the single-cycle decoder.
- EX_ADDR: ALUSrcB=10, ExtOp=1. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD / MEM_WR: IorD=1 and MemRead or MemWrite held until mem_ready, then go to WB_MEM (lw) or IF (sw). mem_ready arriving late stretches the state; the asserted strobe never drops early.
- WB_MEM: MemtoReg=01, RegDst=00, RegWrite=1.

Control transfer
- BR: ALUSrcA=01, ALUSrcB=00, ALUOp=sub, PCWriteCond=1, PCSource=01, BranchNe=OpCode[0].
- JMP: PCWrite=1, PCSource=10. For jal also RegWrite=1, RegDst=10, MemtoReg=10.
- JR: PCWrite=1, PCSource=00 with ALU passing A. For jalr also RegWrite=1, RegDst=01, MemtoReg=10.
- BR, JMP, JR, WB_* and the sw path of MEM_WR all return to IF.

Exceptions
- EXC: EPCWrite=1, PCWrite=1, PCSource=11, then IF. irq is not re-sampled until the next IF.

Cycle counts (mem_ready immediate)
- Branch, jump and jr: 3 cycles.
- R-type, I-type and sw: 4 cycles.
- lw: 5 cycles.

Retired counter
- Increments by 1 on every transition into IF from a non-EXC state.
- Wraps modulo 2^CNT_WIDTH.

Reset mid-instruction
- Immediate return to IF; no further write enables are asserted.

Decomposition:
- Shared package holds: opcode and funct localparams, state encodings, ALUOp, PCSource and RegDst/MemtoReg encodings.
- Natural sub-module: alu_op_decode, combinational OpCode/Funct to ALUOp/ExtOp/LuOp, shared with the single-cycle design.

Test Plan:
1. add, mem_ready tied 1 -> states IF, ID, EX_R, WB_R, IF. RegWrite=1 only in WB_R. retired goes 0 -> 1.
2. lw with mem_ready low 3 cycles in MEM_RD -> MemRead and IorD=1 held 4 cycles, then WB_MEM with MemtoReg=01. Total 8 cycles.
3. beq with Zero=0, then bne with Zero=0 -> PCWriteCond=1 in BR for both. BranchNe=0 then 1, so PC is loaded only for bne.
4. jal -> in JMP: PCWrite=1, RegWrite=1, RegDst=10, MemtoReg=10, PCSource=10. 3 cycles total.
5. OpCode=6'h3f, SUPPORT_EXC=1 -> ID, EXC with EPCWrite=1 and PCSource=11, then IF. retired unchanged.
6. irq high at IF -> EXC taken, no IRWrite. Separately, assert reset in MEM_WR -> MemWrite drops asynchronously, state=IF, retired=0.
